aes_bus_ctrl: RTL and testbench

Register-mapped front end for the `aes_cipher_top` encryption core, sitting between the EIM-side bus decode and the cipher. It holds the plaintext, a bank of selectable 128-bit key slots and the captured ciphertext, and sequences the core's `ld`/`done` handshake. A watchdog aborts hung operations. This is the parametrised successor to the fixed-key, fixed-text wrapper: bus width, key-slot count and timeout are configurable, and host-visible status replaces the hard-wired "good" pin.

---
 rtl/aes_bus_ctrl.sv | 215 +++++++++++++++++++++
 tb/tb_aes_bus_ctrl.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_bus_ctrl.sv
// aes_bus_ctrl: register front end and ld/done sequencer for aes_cipher_top.
// Optional EXPECT register and ciphertext comparator: define AES_BUS_CHECK_EN.
module aes_bus_ctrl #(
  parameter int           DATA_W     = 16,
  parameter int           NUM_KEYS   = 4,
  parameter int           TIMEOUT    = 64,
  parameter logic [127:0] KEY0_RESET = 128'h593847fb7c86cf74a3e54bd76988a510
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              bus_cs,
  input  logic              bus_we,
  input  logic [7:0]        bus_addr,
  input  logic [DATA_W-1:0] bus_wdata,
  output logic [DATA_W-1:0] bus_rdata,
  output logic              core_ld,
  output logic [127:0]      core_key,
  output logic [127:0]      core_text_in,
  input  logic              core_done,
  input  logic [127:0]      core_text_out,
  output logic              irq
);

  localparam int WPB   = 128 / DATA_W;
  localparam int CNT_W = $clog2(TIMEOUT);

  typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [2:0]          slot_q, slot_d;
  logic [127:0]        text_in_q, text_in_d;
  logic [127:0]        text_out_q, text_out_d;
  logic [127:0]        key_q [NUM_KEYS];
  logic [127:0]        key_d [NUM_KEYS];
  logic                done_q, done_d, tmo_q, tmo_d;
  logic                werr_q, werr_d, badslot_q, badslot_d;
  logic                ld_q, ld_d, irq_q, irq_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;

`ifdef AES_BUS_CHECK_EN
  logic [127:0]        expect_q, expect_d;
  logic                match_q, match_d;
`else
  logic                match_q;
  assign match_q = 1'b0;
`endif

  logic       wr, rd, busy, word_ok, key_hit;
  logic [8:0] word_lsb;
  logic [3:0] key_sel;

  assign wr       = bus_cs & bus_we;
  assign rd       = bus_cs & ~bus_we;
  assign busy     = (state_q != IDLE);
  assign word_ok  = ({4'd0, bus_addr[3:0]} < 8'(WPB));
  assign word_lsb = 9'(bus_addr[3:0]) * 9'(DATA_W);
  // Key slot k lives at 0x40 + 16k; the upper nibble minus 4 selects the slot.
  assign key_sel  = bus_addr[7:4] - 4'd4;
  assign key_hit  = (bus_addr >= 8'h40) && ({1'b0, key_sel} < 5'(NUM_KEYS)) && word_ok;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    slot_d     = slot_q;
    text_in_d  = text_in_q;
    text_out_d = text_out_q;
    for (int k = 0; k < NUM_KEYS; k++) key_d[k] = key_q[k];
    done_d     = done_q;
    tmo_d      = tmo_q;
    werr_d     = werr_q;
    badslot_d  = badslot_q;
    ld_d       = 1'b0;
    irq_d      = 1'b0;
    rdata_d    = rdata_q;
`ifdef AES_BUS_CHECK_EN
    expect_d   = expect_q;
    match_d    = match_q;
`endif

    if (wr) begin
      if (bus_addr[7:4] == 4'h0 && word_ok) begin
        if (busy) werr_d = 1'b1;
        else      text_in_d[word_lsb +: DATA_W] = bus_wdata;
      end
      if (key_hit) begin
        if (busy) werr_d = 1'b1;
        else begin
          for (int k = 0; k < NUM_KEYS; k++)
            if (key_sel == 4'(k)) key_d[k][word_lsb +: DATA_W] = bus_wdata;
        end
      end
`ifdef AES_BUS_CHECK_EN
      if (bus_addr[7:4] == 4'h2 && word_ok) begin
        if (busy) werr_d = 1'b1;
        else      expect_d[word_lsb +: DATA_W] = bus_wdata;
      end
`endif
      if (bus_addr == 8'h30) begin
        if (bus_wdata[15]) begin
          done_d    = 1'b0;
          tmo_d     = 1'b0;
          werr_d    = 1'b0;
          badslot_d = 1'b0;
        end
        if (bus_wdata[0] && !busy) begin
          if ({1'b0, bus_wdata[3:1]} >= 4'(NUM_KEYS)) begin
            badslot_d = 1'b1;
          end else begin
            slot_d  = bus_wdata[3:1];
            done_d  = 1'b0;
            tmo_d   = 1'b0;
`ifdef AES_BUS_CHECK_EN
            match_d = 1'b0;
`endif
            state_d = LOAD;
            ld_d    = 1'b1;
          end
        end
      end
    end

    // Completion and abort are evaluated after the bus so they win over CLR.
    case (state_q)
      LOAD: begin
        state_d = RUN;
        cnt_d   = '0;
      end
      RUN: begin
        if (core_done) begin
          text_out_d = core_text_out;
          done_d     = 1'b1;
          irq_d      = 1'b1;
          state_d    = IDLE;
`ifdef AES_BUS_CHECK_EN
          match_d    = (core_text_out == expect_q);
`endif
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          tmo_d   = 1'b1;
          irq_d   = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: ;
    endcase

    if (rd) begin
      rdata_d = '0;
      case (bus_addr[7:4])
        4'h0: if (word_ok) rdata_d = text_in_q[word_lsb +: DATA_W];
        4'h1: if (word_ok) rdata_d = text_out_q[word_lsb +: DATA_W];
`ifdef AES_BUS_CHECK_EN
        4'h2: if (word_ok) rdata_d = expect_q[word_lsb +: DATA_W];
`endif
        4'h3: if (bus_addr[3:0] == 4'h1)
                rdata_d[5:0] = {badslot_q, match_q, werr_q, tmo_q, done_q, busy};
        default: ;
      endcase
    end
  end

  always_comb begin
    core_key = key_q[0];
    for (int k = 1; k < NUM_KEYS; k++)
      if (slot_q == 3'(k)) core_key = key_q[k];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      slot_q     <= '0;
      text_in_q  <= '0;
      text_out_q <= '0;
      for (int k = 0; k < NUM_KEYS; k++) key_q[k] <= (k == 0) ? KEY0_RESET : '0;
      done_q     <= 1'b0;
      tmo_q      <= 1'b0;
      werr_q     <= 1'b0;
      badslot_q  <= 1'b0;
      ld_q       <= 1'b0;
      irq_q      <= 1'b0;
      rdata_q    <= '0;
`ifdef AES_BUS_CHECK_EN
      expect_q   <= '0;
      match_q    <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      slot_q     <= slot_d;
      text_in_q  <= text_in_d;
      text_out_q <= text_out_d;
      for (int k = 0; k < NUM_KEYS; k++) key_q[k] <= key_d[k];
      done_q     <= done_d;
      tmo_q      <= tmo_d;
      werr_q     <= werr_d;
      badslot_q  <= badslot_d;
      ld_q       <= ld_d;
      irq_q      <= irq_d;
      rdata_q    <= rdata_d;
`ifdef AES_BUS_CHECK_EN
      expect_q   <= expect_d;
      match_q    <= match_d;
`endif
    end
  end

  assign bus_rdata    = rdata_q;
  assign core_ld      = ld_q;
  assign irq          = irq_q;
  assign core_text_in = text_in_q;

endmodule

// File: tb/tb_aes_bus_ctrl.sv
// tb_aes_bus_ctrl: self-checking bench for aes_bus_ctrl with a behavioural cipher stub.
// Follows AES_BUS_CHECK_EN so the same bench works on either build.
module tb_aes_bus_ctrl;
  localparam int DATA_W   = 16;
  localparam int NUM_KEYS = 4;
  localparam int TIMEOUT  = 64;
  localparam int WPB      = 128 / DATA_W;
  localparam logic [127:0] KEY0     = 128'h593847fb7c86cf74a3e54bd76988a510;
  localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
`ifdef AES_BUS_CHECK_EN
  localparam bit CHECK = 1'b1;
`else
  localparam bit CHECK = 1'b0;
`endif

  logic              clk = 1'b0, rst = 1'b1, bus_cs = 1'b0, bus_we = 1'b0;
  logic [7:0]        bus_addr = '0;
  logic [DATA_W-1:0] bus_wdata = '0;
  logic [DATA_W-1:0] bus_rdata;
  logic              core_ld, irq;
  logic [127:0]      core_key, core_text_in;
  logic              core_done = 1'b0;
  logic [127:0]      core_text_out = '0;

  aes_bus_ctrl #(.DATA_W(DATA_W), .NUM_KEYS(NUM_KEYS), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .bus_cs(bus_cs), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .core_ld(core_ld), .core_key(core_key),
    .core_text_in(core_text_in), .core_done(core_done), .core_text_out(core_text_out),
    .irq(irq)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0;
  int cyc = 0, ld_cnt = 0, irq_cnt = 0, ld_cyc = 0, irq_cyc = 0;
  int stub_lat = 4, stub_cnt = 0;
  logic [127:0] ld_key = '0, ld_text = '0;

  // Behavioural stand-in for the cipher: known answer for FIPS-197, a keyed mix otherwise.
  function automatic logic [127:0] cipher(input logic [127:0] k, input logic [127:0] t);
    if (k == FIPS_KEY && t == FIPS_PT) return FIPS_CT;
    return {k[63:0] ^ t[127:64], k[127:64] + t[63:0]};
  endfunction

  always @(posedge clk) cyc++;

  // Stub core plus pulse monitors; everything is sampled mid-cycle.
  always @(negedge clk) begin
    if (rst) begin
      core_done = 1'b0;
      stub_cnt  = 0;
    end else if (core_ld) begin
      ld_cnt++;
      ld_cyc    = cyc;
      ld_key    = core_key;
      ld_text   = core_text_in;
      core_done = 1'b0;
      stub_cnt  = stub_lat;
    end else if (stub_cnt > 0) begin
      stub_cnt--;
      if (stub_cnt == 0) begin
        core_done     = 1'b1;
        core_text_out = cipher(ld_key, ld_text);
      end
    end
    if (irq) begin
      irq_cnt++;
      irq_cyc = cyc;
    end
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: actual %h required %h", name, act, req);
    end
  endtask

  task automatic bus_write(input logic [7:0] a, input logic [DATA_W-1:0] d);
    @(negedge clk);
    bus_cs = 1'b1; bus_we = 1'b1; bus_addr = a; bus_wdata = d;
    @(posedge clk);
    #1;
    bus_cs = 1'b0; bus_we = 1'b0;
    $display("[%0d] wr addr=%02h data=%h", cyc, a, d);
  endtask

  task automatic bus_read(input logic [7:0] a, output logic [DATA_W-1:0] d);
    @(negedge clk);
    bus_cs = 1'b1; bus_we = 1'b0; bus_addr = a;
    @(posedge clk);
    #1;
    bus_cs = 1'b0;
    d = bus_rdata;
    $display("[%0d] rd addr=%02h data=%h", cyc, a, d);
  endtask

  // ---------------- reference model (register-level, cycle-free) ----------------
  logic [127:0] m_text, m_out, m_exp;
  logic [127:0] m_key [NUM_KEYS];
  int           m_slot;
  bit           m_done, m_tmo, m_werr, m_match, m_bad;

  task automatic model_reset();
    m_text = '0; m_out = '0; m_exp = '0; m_slot = 0;
    for (int k = 0; k < NUM_KEYS; k++) m_key[k] = (k == 0) ? KEY0 : '0;
    {m_done, m_tmo, m_werr, m_match, m_bad} = '0;
  endtask

  function automatic logic [DATA_W-1:0] model_read(input logic [7:0] a);
    int i = int'(a[3:0]);
    logic [127:0] v = '0;
    if (a[7:4] == 4'h0 && i < WPB) v = m_text >> (i * DATA_W);
    else if (a[7:4] == 4'h1 && i < WPB) v = m_out >> (i * DATA_W);
    else if (CHECK && a[7:4] == 4'h2 && i < WPB) v = m_exp >> (i * DATA_W);
    else if (a == 8'h31) v = 128'({m_bad, m_match, m_werr, m_tmo, m_done, 1'b0});
    return v[DATA_W-1:0];
  endfunction

  // Applies an idle-time write; a valid START is resolved to its final outcome at once.
  task automatic model_write(input logic [7:0] a, input logic [DATA_W-1:0] d, output bit started);
    int i = int'(a[3:0]);
    int k = int'(a[7:4]) - 4;
    started = 1'b0;
    if (a[7:4] == 4'h0 && i < WPB) m_text[i*DATA_W +: DATA_W] = d;
    if (a >= 8'h40 && k < NUM_KEYS && i < WPB) m_key[k][i*DATA_W +: DATA_W] = d;
    if (CHECK && a[7:4] == 4'h2 && i < WPB) m_exp[i*DATA_W +: DATA_W] = d;
    if (a == 8'h30) begin
      if (d[15]) {m_done, m_tmo, m_werr, m_bad} = '0;
      if (d[0]) begin
        if (int'(d[3:1]) >= NUM_KEYS) m_bad = 1'b1;
        else begin
          started = 1'b1;
          m_slot  = int'(d[3:1]);
          m_match = 1'b0;
          if (stub_lat > 0) begin
            m_out   = cipher(m_key[m_slot], m_text);
            m_done  = 1'b1;
            m_tmo   = 1'b0;
            m_match = CHECK && (m_out == m_exp);
          end else begin
            m_done = 1'b0;
            m_tmo  = 1'b1;
          end
        end
      end
    end
  endtask

  task automatic wait_irq(input int base, input string name);
    int n = 0;
    while (irq_cnt == base && n < TIMEOUT + 40) begin
      @(negedge clk);
      #1;
      n++;
    end
    check(name, 128'(irq_cnt - base), 128'(1));
    @(negedge clk);
  endtask

  int start_cyc = 0;
  task automatic op_write(input logic [7:0] a, input logic [DATA_W-1:0] d, input bit wait_end);
    int base = irq_cnt;
    bit started;
    bus_write(a, d);
    start_cyc = cyc;
    model_write(a, d, started);
    if (started && wait_end) wait_irq(base, "irq_count");
  endtask

  typedef struct packed {
    logic              we;
    logic [7:0]        addr;
    logic [DATA_W-1:0] data;
    logic [DATA_W-1:0] exp;
  } vec_t;
  vec_t vecs [21];

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [DATA_W-1:0] rd;
    int ldc, base;

    vecs[0]  = '{1'b1, 8'h00, 16'h1111, 16'h0000};
    vecs[1]  = '{1'b1, 8'h01, 16'h2222, 16'h0000};
    vecs[2]  = '{1'b1, 8'h07, 16'h7777, 16'h0000};
    vecs[3]  = '{1'b0, 8'h00, 16'h0000, 16'h1111};
    vecs[4]  = '{1'b0, 8'h01, 16'h0000, 16'h2222};
    vecs[5]  = '{1'b0, 8'h07, 16'h0000, 16'h7777};
    vecs[6]  = '{1'b0, 8'h08, 16'h0000, 16'h0000};
    vecs[7]  = '{1'b0, 8'h10, 16'h0000, 16'h0000};
    vecs[8]  = '{1'b1, 8'h20, 16'habcd, 16'h0000};
    vecs[9]  = '{1'b0, 8'h20, 16'h0000, CHECK ? 16'habcd : 16'h0000};
    vecs[10] = '{1'b1, 8'h40, 16'hdead, 16'h0000};
    vecs[11] = '{1'b0, 8'h40, 16'h0000, 16'h0000};
    vecs[12] = '{1'b1, 8'h31, 16'hffff, 16'h0000};
    vecs[13] = '{1'b0, 8'h31, 16'h0000, 16'h0000};
    vecs[14] = '{1'b1, 8'h30, 16'h0009, 16'h0000};
    vecs[15] = '{1'b0, 8'h31, 16'h0000, 16'h0020};
    vecs[16] = '{1'b1, 8'h30, 16'h8000, 16'h0000};
    vecs[17] = '{1'b0, 8'h31, 16'h0000, 16'h0000};
    vecs[18] = '{1'b0, 8'h30, 16'h0000, 16'h0000};
    vecs[19] = '{1'b1, 8'h0f, 16'h5555, 16'h0000};
    vecs[20] = '{1'b0, 8'h0f, 16'h0000, 16'h0000};

    // Reset state
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_rdata", 128'(bus_rdata), 128'(0));
    check("rst_ld", 128'(core_ld), 128'(0));
    check("rst_irq", 128'(irq), 128'(0));
    check("rst_key", core_key, KEY0);
    check("rst_text_in", core_text_in, 128'(0));
    rst = 1'b0;
    bus_read(8'h31, rd); check("rst_status", 128'(rd), 128'(0));
    bus_read(8'h40, rd); check("rst_slot0_w0", 128'(rd), 128'(0));

    // Register map vectors
    for (int v = 0; v < 21; v++) begin
      if (vecs[v].we) op_write(vecs[v].addr, vecs[v].data, 1'b0);
      else begin
        bus_read(vecs[v].addr, rd);
        check($sformatf("vec%0d_addr%02h", v, vecs[v].addr), 128'(rd), 128'(vecs[v].exp));
      end
    end
    check("badslot_no_ld", 128'(ld_cnt), 128'(0));
    check("key0_word_write", core_key, m_key[0]);
    repeat (3) @(negedge clk);
    check("rdata_hold", 128'(bus_rdata), 128'(0));

    // FIPS-197 vector through slot 1
    for (int i = 0; i < WPB; i++) op_write(8'(8'h50 + i), FIPS_KEY[i*DATA_W +: DATA_W], 1'b0);
    for (int i = 0; i < WPB; i++) op_write(8'(i), FIPS_PT[i*DATA_W +: DATA_W], 1'b0);
    for (int i = 0; i < WPB; i++) op_write(8'(8'h20 + i), FIPS_CT[i*DATA_W +: DATA_W], 1'b0);
    stub_lat = 5;
    ldc = ld_cnt; base = irq_cnt;
    op_write(8'h30, 16'h0003, 1'b0);
    bus_read(8'h31, rd); check("fips_busy_status", 128'(rd), 128'h1);
    wait_irq(base, "fips_irq");
    check("fips_ld_count", 128'(ld_cnt - ldc), 128'(1));
    check("fips_ld_timing", 128'(ld_cyc - start_cyc), 128'(0));
    check("fips_irq_timing", 128'(irq_cyc - start_cyc), 128'(6));
    check("fips_core_key", ld_key, FIPS_KEY);
    check("fips_core_text", ld_text, FIPS_PT);
    for (int i = 0; i < WPB; i++) begin
      bus_read(8'(8'h10 + i), rd);
      check($sformatf("fips_text_out_w%0d", i), 128'(rd), 128'(FIPS_CT[i*DATA_W +: DATA_W]));
    end
    bus_read(8'h31, rd); check("fips_status", 128'(rd), CHECK ? 128'h12 : 128'h02);

    // Same vector against a wrong EXPECT: MATCH must stay low
    for (int i = 0; i < WPB; i++) op_write(8'(8'h20 + i), ~FIPS_CT[i*DATA_W +: DATA_W], 1'b0);
    op_write(8'h30, 16'h0003, 1'b1);
    bus_read(8'h31, rd); check("wrong_expect_status", 128'(rd), 128'h02);

    // Timeout with core_done held low
    stub_lat = 0;
    op_write(8'h30, 16'h0001, 1'b1);
    check("tmo_irq_timing", 128'(irq_cyc - start_cyc), 128'(TIMEOUT + 1));
    bus_read(8'h31, rd); check("tmo_status", 128'(rd), 128'h04);
    bus_read(8'h10, rd); check("tmo_text_out_kept", 128'(rd), 128'(FIPS_CT[DATA_W-1:0]));
    op_write(8'h30, 16'h8000, 1'b0);
    bus_read(8'h31, rd); check("clr_status", 128'(rd), 128'h00);

    // Writes and START while busy are dropped
    stub_lat = 30;
    ldc = ld_cnt; base = irq_cnt;
    op_write(8'h30, 16'h0001, 1'b0);
    repeat (3) @(negedge clk);
    bus_write(8'h00, 16'hbeef);
    bus_write(8'h30, 16'h0001);
    bus_write(8'h40, 16'h1234);
    m_werr = 1'b1;
    check("busy_text_in_stable", core_text_in, m_text);
    wait_irq(base, "busy_irq");
    check("busy_ld_count", 128'(ld_cnt - ldc), 128'(1));
    check("busy_key_stable", core_key, m_key[0]);
    bus_read(8'h00, rd); check("busy_text_in_w0", 128'(rd), 128'(m_text[DATA_W-1:0]));
    bus_read(8'h31, rd); check("busy_status", 128'(rd), 128'h0a);
    op_write(8'h30, 16'h8000, 1'b0);

    // Randomized traffic against the model
    for (int n = 0; n < 60; n++) begin
      logic [7:0] a;
      logic [DATA_W-1:0] d;
      int r = int'($urandom_range(0, 9));
      d = DATA_W'($urandom);
      if (r <= 2) op_write(8'($urandom_range(0, 15)), d, 1'b0);
      else if (r <= 4) op_write(8'(8'h40 + 16 * $urandom_range(0, NUM_KEYS) + $urandom_range(0, WPB - 1)), d, 1'b0);
      else if (r == 5) op_write(8'(8'h20 + $urandom_range(0, 15)), d, 1'b0);
      else if (r == 6) op_write(8'h30, 16'h8000, 1'b0);
      else if (r <= 8) begin
        stub_lat = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, 20));
        ldc = ld_cnt;
        d = DATA_W'({$urandom_range(0, 1), 11'd0, 3'($urandom_range(0, NUM_KEYS)), 1'b1});
        op_write(8'h30, d, 1'b1);
        check("rnd_ld_count", 128'(ld_cnt - ldc), 128'(int'(d[3:1]) < NUM_KEYS ? 1 : 0));
      end
      case ($urandom_range(0, 4))
        0: a = 8'($urandom_range(0, 15));
        1: a = 8'(8'h10 + $urandom_range(0, 15));
        2: a = 8'(8'h20 + $urandom_range(0, 15));
        3: a = 8'h31;
        default: a = 8'($urandom_range(0, 255));
      endcase
      bus_read(a, rd);
      check($sformatf("rnd%0d_rd%02h", n, a), 128'(rd), 128'(model_read(a)));
      check("rnd_core_key", core_key, m_key[m_slot]);
      check("rnd_core_text_in", core_text_in, m_text);
    end

    // Asynchronous reset in the middle of an operation
    stub_lat = 10;
    op_write(8'h30, 16'h0001, 1'b0);
    check("ld_before_rst", 128'(core_ld), 128'(1));
    #2 rst = 1'b1;
    #1;
    check("async_rst_ld", 128'(core_ld), 128'(0));
    check("async_rst_key", core_key, KEY0);
    check("async_rst_text", core_text_in, 128'(0));
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    bus_read(8'h31, rd); check("post_rst_status", 128'(rd), 128'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
